// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ready/valid ALU between NREQ lanes. An in-order
// tag FIFO steers each ALU result back to the lane that issued the operation.
module alu_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
  output logic [WIDTH-1:0]      alu_a_out,
  output logic [WIDTH-1:0]      alu_b_out,
  output logic                  alu_op_out,
  output logic                  alu_valid_out,
  input  logic                  alu_ready_in,
  input  logic [WIDTH-1:0]      alu_result_in,
  input  logic                  alu_result_valid_in,
  output logic                  alu_result_ready_out,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0] rrPtr_q, rrPtr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lockId_q, lockId_d;
  logic           err_q, err_d;
  logic [PW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IDW-1:0] tagMem_q [MAX_OUT];

  logic [IDW-1:0] grantId;
  logic [IDW-1:0] scanIdx;
  logic           found;
  logic           hasGrant;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [IDW-1:0] headId;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Locked grant wins; otherwise scan upward from rrPtr_q with wraparound.
  always_comb begin
    grantId = lockId_q;
    scanIdx = '0;
    found   = 1'b0;
    if (!lock_q) begin
      for (int k = 0; k < NREQ; k++) begin
        scanIdx = IDW'((int'(rrPtr_q) + k) % NREQ);
        if (!found && req_valid[scanIdx]) begin
          grantId = scanIdx;
          found   = 1'b1;
        end
      end
    end
  end

  assign hasGrant  = reset & (lock_q | (|req_valid));
  assign fifoFull  = (count_q == CW'(MAX_OUT));
  assign fifoEmpty = (count_q == '0);
  assign headId    = tagMem_q[rdPtr_q];

  always_comb begin
    req_ready            = '0;
    alu_a_out            = '0;
    alu_b_out            = '0;
    alu_op_out           = 1'b0;
    alu_valid_out        = hasGrant & !fifoFull;
    rsp_valid            = '0;
    rsp_data             = reset ? alu_result_in : '0;
    alu_result_ready_out = reset & !fifoEmpty & rsp_ready[headId];
    if (hasGrant) begin
      alu_a_out  = req_a[grantId*WIDTH +: WIDTH];
      alu_b_out  = req_b[grantId*WIDTH +: WIDTH];
      alu_op_out = req_op[grantId];
      req_ready[grantId] = alu_ready_in & !fifoFull;
    end
    if (reset && alu_result_valid_in && !fifoEmpty) begin
      rsp_valid = NREQ'(1) << headId;
    end
  end

  assign push = alu_valid_out & alu_ready_in;
  assign pop  = alu_result_valid_in & alu_result_ready_out;
  assign err  = err_q;

  // A dropped request while locked overrides the relock so the lane is released.
  always_comb begin
    rrPtr_d  = rrPtr_q;
    lock_d   = lock_q;
    lockId_d = lockId_q;
    err_d    = err_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    if (push) begin
      rrPtr_d = (grantId == IDW'(NREQ - 1)) ? '0 : grantId + IDW'(1);
      lock_d  = 1'b0;
      wrPtr_d = ptrInc(wrPtr_q);
    end else if (alu_valid_out) begin
      lock_d   = 1'b1;
      lockId_d = grantId;
    end
    if (lock_q && !req_valid[lockId_q]) begin
      err_d  = 1'b1;
      lock_d = 1'b0;
    end
    if (alu_result_valid_in && fifoEmpty) begin
      err_d = 1'b1;
    end
    if (pop) begin
      rdPtr_d = ptrInc(rdPtr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr_q  <= '0;
      lock_q   <= 1'b0;
      lockId_q <= '0;
      err_q    <= 1'b0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        tagMem_q[i] <= '0;
      end
    end else begin
      rrPtr_q  <= rrPtr_d;
      lock_q   <= lock_d;
      lockId_q <= lockId_d;
      err_q    <= err_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      if (push) begin
        tagMem_q[wrPtr_q] <= grantId;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: the bench plays the ALU and all four lanes,
// with hand-computed expected grants, steering and error behaviour.
module tb_alu_req_arbiter;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int MAX_OUT = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_op;
  logic [WIDTH-1:0]      alu_a_out;
  logic [WIDTH-1:0]      alu_b_out;
  logic                  alu_op_out;
  logic                  alu_valid_out;
  logic                  alu_ready_in;
  logic [WIDTH-1:0]      alu_result_in;
  logic                  alu_result_valid_in;
  logic                  alu_result_ready_out;
  logic [WIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic                  err;

  int vectors;
  int miscompares;

  alu_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_a                (req_a),
    .req_b                (req_b),
    .req_op               (req_op),
    .alu_a_out            (alu_a_out),
    .alu_b_out            (alu_b_out),
    .alu_op_out           (alu_op_out),
    .alu_valid_out        (alu_valid_out),
    .alu_ready_in         (alu_ready_in),
    .alu_result_in        (alu_result_in),
    .alu_result_valid_in  (alu_result_valid_in),
    .alu_result_ready_out (alu_result_ready_out),
    .rsp_data             (rsp_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .err                  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i carries a = i+1, b = i+2; lane 3 requests a multiply.
  function automatic logic [31:0] laneA(input int i);
    return 32'(i + 1);
  endfunction

  function automatic logic [31:0] laneB(input int i);
    return 32'(i + 2);
  endfunction

  function automatic logic laneOp(input int i);
    return (i == 3);
  endfunction

  function automatic logic [31:0] laneResult(input int i);
    return laneOp(i) ? laneA(i) * laneB(i) : laneA(i) + laneB(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // expId < 0 means no lane should be granted an issue this cycle.
  task automatic checkIssue(input string tag, input int expId);
    if (expId < 0) begin
      checkOutput({tag, ".ready"}, 32'(req_ready), 32'h0);
      checkOutput({tag, ".valid"}, 32'(alu_valid_out), 32'h0);
    end else begin
      checkOutput({tag, ".ready"}, 32'(req_ready), 32'(1) << expId);
      checkOutput({tag, ".valid"}, 32'(alu_valid_out), 32'h1);
      checkOutput({tag, ".a"}, alu_a_out, laneA(expId));
      checkOutput({tag, ".b"}, alu_b_out, laneB(expId));
      checkOutput({tag, ".op"}, 32'(alu_op_out), 32'(laneOp(expId)));
    end
  endtask

  // expId < 0 means no response may be steered this cycle.
  task automatic checkRsp(input string tag, input int expId, input logic expAccept);
    if (expId < 0) begin
      checkOutput({tag, ".rspv"}, 32'(rsp_valid), 32'h0);
    end else begin
      checkOutput({tag, ".rspv"}, 32'(rsp_valid), 32'(1) << expId);
      checkOutput({tag, ".data"}, rsp_data, laneResult(expId));
    end
    checkOutput({tag, ".rready"}, 32'(alu_result_ready_out), 32'(expAccept));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // resId >= 0 presents that lane's result on the ALU result port.
  task automatic applyStimulus(input logic [3:0] valid, input logic aluReady, input int resId,
                               input logic [3:0] rspRdy);
    req_valid           = valid;
    alu_ready_in        = aluReady;
    alu_result_valid_in = (resId >= 0);
    alu_result_in       = (resId >= 0) ? laneResult(resId) : 32'h0;
    rsp_ready           = rspRdy;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = laneA(i);
      req_b[i*WIDTH +: WIDTH] = laneB(i);
      req_op[i]               = laneOp(i);
    end

    reset = 1'b0;
    applyStimulus(4'hF, 1'b1, 0, 4'hF);
    checkIssue("rst", -1);
    checkRsp("rst", -1, 1'b0);
    checkOutput("rst.a", alu_a_out, 32'h0);
    checkOutput("rst.data", rsp_data, 32'h0);
    checkOutput("rst.err", 32'(err), 32'h0);

    // Round robin: 2-cycle ALU latency, issue order 0,1,2,3,0.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'hF, 1'b1, -1, 4'hF);
    checkIssue("rr0", 0);
    nextCycle(); applyStimulus(4'hF, 1'b1, -1, 4'hF);
    checkIssue("rr1", 1);
    nextCycle(); applyStimulus(4'hF, 1'b1, 0, 4'hF);
    checkIssue("rr2full", -1);
    checkRsp("rr2", 0, 1'b1);
    nextCycle(); applyStimulus(4'hF, 1'b1, 1, 4'hF);
    checkIssue("rr3", 2);
    checkRsp("rr3", 1, 1'b1);
    nextCycle(); applyStimulus(4'hF, 1'b1, 2, 4'hF);
    checkIssue("rr4", 3);
    checkRsp("rr4", 2, 1'b1);
    nextCycle(); applyStimulus(4'hF, 1'b1, 3, 4'hF);
    checkIssue("rr5", 0);
    checkRsp("rr5", 3, 1'b1);
    nextCycle(); applyStimulus(4'h0, 1'b1, 0, 4'hF);
    checkIssue("rr6", -1);
    checkRsp("rr6", 0, 1'b1);

    // Grant lock: lane 1 held for 3 stalled cycles while lane 0 joins.
    nextCycle(); applyStimulus(4'b0010, 1'b0, -1, 4'hF);
    checkOutput("lock0.a", alu_a_out, laneA(1));
    checkOutput("lock0.ready", 32'(req_ready), 32'h0);
    nextCycle(); applyStimulus(4'b0011, 1'b0, -1, 4'hF);
    checkOutput("lock1.a", alu_a_out, laneA(1));
    checkOutput("lock1.valid", 32'(alu_valid_out), 32'h1);
    nextCycle(); applyStimulus(4'b0011, 1'b0, -1, 4'hF);
    checkOutput("lock2.a", alu_a_out, laneA(1));
    nextCycle(); applyStimulus(4'b0011, 1'b1, -1, 4'hF);
    checkIssue("lock3", 1);
    nextCycle(); applyStimulus(4'b0001, 1'b1, -1, 4'hF);
    checkIssue("lock4", 0);
    nextCycle(); applyStimulus(4'h0, 1'b1, 1, 4'hF);
    checkRsp("lock5", 1, 1'b1);
    nextCycle(); applyStimulus(4'h0, 1'b1, 0, 4'hF);
    checkRsp("lock6", 0, 1'b1);

    // FIFO full: two issues fill it, a same-cycle pop does not allow a push.
    nextCycle(); applyStimulus(4'b0111, 1'b1, -1, 4'hF);
    checkIssue("full0", 1);
    nextCycle(); applyStimulus(4'b0111, 1'b1, -1, 4'hF);
    checkIssue("full1", 2);
    nextCycle(); applyStimulus(4'b0111, 1'b1, -1, 4'hF);
    checkIssue("full2", -1);
    nextCycle(); applyStimulus(4'b0111, 1'b1, 1, 4'hF);
    checkIssue("full3pop", -1);
    checkRsp("full3", 1, 1'b1);
    nextCycle(); applyStimulus(4'b0111, 1'b1, -1, 4'hF);
    checkIssue("full4resume", 0);

    // Response back-pressure: head lane 2 not ready for 4 cycles.
    for (int c = 0; c < 4; c++) begin
      nextCycle(); applyStimulus(4'h0, 1'b1, 2, 4'b1011);
      checkRsp($sformatf("bp%0d", c), 2, 1'b0);
    end
    nextCycle(); applyStimulus(4'h0, 1'b1, 2, 4'hF);
    checkRsp("bp4", 2, 1'b1);
    nextCycle(); applyStimulus(4'h0, 1'b1, 0, 4'hF);
    checkRsp("bp5", 0, 1'b1);

    // Spurious result with an empty FIFO raises a sticky err.
    nextCycle(); applyStimulus(4'h0, 1'b1, 1, 4'hF);
    checkRsp("spur0", -1, 1'b0);
    checkOutput("spur0.err", 32'(err), 32'h0);
    nextCycle(); applyStimulus(4'h0, 1'b1, -1, 4'hF);
    checkOutput("spur1.err", 32'(err), 32'h1);
    nextCycle(); applyStimulus(4'h0, 1'b1, -1, 4'hF);
    checkOutput("spur2.err", 32'(err), 32'h1);

    // Mid-flight reset with two operations outstanding.
    nextCycle(); applyStimulus(4'b0011, 1'b1, -1, 4'hF);
    checkIssue("mid0", 1);
    nextCycle(); applyStimulus(4'b0011, 1'b1, -1, 4'hF);
    checkIssue("mid1", 0);
    nextCycle(); applyStimulus(4'b0101, 1'b1, 1, 4'hF);
    #1 reset = 1'b0;
    #1;
    checkIssue("midrst", -1);
    checkRsp("midrst", -1, 1'b0);
    checkOutput("midrst.a", alu_a_out, 32'h0);
    checkOutput("midrst.data", rsp_data, 32'h0);
    checkOutput("midrst.err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b0101, 1'b1, -1, 4'hF);
    checkIssue("post", 0);
    checkOutput("post.err", 32'(err), 32'h0);
    nextCycle(); applyStimulus(4'h0, 1'b1, -1, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

- Shares one latency-insensitive ALU (ready/valid, op 0 = add, 1 = multiply) between NREQ requesters.
- Requests are arbitrated round-robin. The grant is locked until the ALU accepts it, so the presented payload stays stable.
- Each issued requester ID is pushed into an in-order tag FIFO, and each ALU result is steered back to the requester whose ID is at the FIFO head.
- The block sits between the requesting compute lanes and the ALU wrapper. It adds no register stage on the request or response data paths.

## Interface

Parameters:
- WIDTH, 32, operand/result width
- NREQ, 4, number of requesters (2..16)
- MAX_OUT, 2, tag FIFO depth = maximum outstanding ALU operations (1..8)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester request accepted
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_op  input  NREQ  per-requester op
- alu_a_out  output  WIDTH  operand A to ALU
- alu_b_out  output  WIDTH  operand B to ALU
- alu_op_out  output  1  op to ALU
- alu_valid_out  output  1  request valid to ALU
- alu_ready_in  input  1  ALU ready to accept
- alu_result_in  input  WIDTH  ALU result
- alu_result_valid_in  input  1  ALU result valid
- alu_result_ready_out  output  1  result accepted by arbiter
- rsp_data  output  WIDTH  result, broadcast to all requesters
- rsp_valid  output  NREQ  one-hot response valid
- rsp_ready  input  NREQ  per-requester response ready
- err  output  1  sticky protocol error flag

## Operation

**State**
- rr_ptr: log2(NREQ) bits, highest-priority index.
- lock: 1 bit.
- lock_id: granted index.
- Tag FIFO: MAX_OUT entries, with read/write pointers and an occupancy count (0..MAX_OUT).
- err.

**Grant selection**
- When lock=0: grant = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ.
- When lock=1: grant = lock_id, regardless of other requests.

**Issue to ALU**
- alu_valid_out = (lock | any req_valid) & !fifo_full.
- alu_a_out, alu_b_out and alu_op_out mux the payload of the granted requester.
- With no grant, the outputs are 0.
- req_ready[g] = alu_ready_in & !fifo_full, for the granted index g only; all other req_ready bits are 0.
- Issue handshake = alu_valid_out & alu_ready_in. On issue:
  - push g into the tag FIFO;
  - set rr_ptr = (g+1) mod NREQ;
  - clear lock.
- If alu_valid_out=1 and alu_ready_in=0: set lock=1 and lock_id=g.
- Requesters must hold req_valid and payload until req_ready. Dropping req_valid while locked is a protocol error: set err, clear lock.

**Response steering**
- h = FIFO head ID.
- rsp_valid[h] = alu_result_valid_in & !fifo_empty; all other rsp_valid bits are 0.
- rsp_data = alu_result_in.
- alu_result_ready_out = rsp_ready[h] & !fifo_empty.
- Response handshake pops the FIFO.
- alu_result_valid_in while the FIFO is empty sets err. The result is not accepted (alu_result_ready_out=0).

**Boundary conditions**
- FIFO full: no issue. A pop in the same cycle does not enable a push; issue resumes the next cycle.
- Push and pop in the same cycle (FIFO not full): occupancy is unchanged and both pointers advance.
- Pointers wrap modulo MAX_OUT.
- err is cleared only by reset.

## Timing

- **Reset** (asynchronous assertion, synchronous deassertion by integration):
  - rr_ptr=0, lock=0, FIFO empty, err=0.
  - While reset is low, req_ready, alu_valid_out, alu_result_ready_out and rsp_valid are forced to 0.
  - Data outputs are 0 while reset is low.
- **Reset mid-operation:** outstanding tags are discarded. Results that arrive afterwards set err (FIFO empty).
- **Latency:** request to ALU is 0 cycles (combinational). ALU result to rsp is 0 cycles.
- **Throughput:** one issue per cycle while the FIFO is not full. Sustained rate is bounded by MAX_OUT over the ALU round-trip latency.
- **Independence:** alu_valid_out never depends on alu_ready_in. rsp_valid never depends on rsp_ready.
- **Fairness:** a continuously valid requester is granted within NREQ issue handshakes.

## Test plan

- **Round-robin fairness:** NREQ=4, all four req_valid held high, ALU always ready, 2-cycle result latency → issue order 0,1,2,3,0; each rsp_valid one-hot to the matching index; rsp_data = a+b per lane (e.g. lane 2: 3+4 → 7).
- **Grant lock:** req 1 valid, alu_ready_in=0 for 3 cycles, req 0 asserts in cycle 2 → alu_a_out remains req 1's payload until the handshake; req 0 is issued next.
- **FIFO full:** MAX_OUT=2, ALU accepts but withholds results → the third request sees req_ready=0 and alu_valid_out=0. After one result pop, issue resumes in the next cycle.
- **Response back-pressure:** head owner has rsp_ready=0 for 4 cycles → alu_result_ready_out=0; no pop; other rsp_valid bits stay 0.
- **Spurious result:** alu_result_valid_in=1 with the FIFO empty → err=1 next cycle, and err stays 1.
- **Mid-flight reset:** two ops outstanding, reset pulsed low → all outputs 0 immediately; after release, rr_ptr=0, the first grant goes to the lowest valid index, and err=0.
